// File: rtl/ic_bd_transpose_ctrl_pkg.sv
// Shared definitions for the bindct transpose-buffer controller.
// Holds the state encoding, the default block geometry and the data-path widths.
package ic_bd_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned ROWS_DEFAULT  = 8;
  localparam int unsigned CNT_W_DEFAULT = 4;
  localparam int unsigned ROW_W         = 96;
  localparam int unsigned ELEM_W        = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_FILL  = FILL,
    ST_DRAIN = DRAIN
  } state_e;

endpackage

// File: rtl/ic_bd_transpose_ctrl_if.sv
// Handshake and buffer-control bundle of the transpose controller.
// The blk_cnt member exists only when IC_BD_TRANSPOSE_CTRL_BLKCNT_EN is defined.
interface ic_bd_transpose_ctrl_if
  import ic_bd_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) ();

  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             tm_write;
  logic             tm_read;
  logic             tm_empty;
  logic             tm_full;
  logic [CNT_W-1:0] out_row;
  logic             out_last;
  logic             busy;
  logic             err;
`ifdef IC_BD_TRANSPOSE_CTRL_BLKCNT_EN
  logic [15:0]      blk_cnt;
`endif

  // Controller side.
  modport master (
    input  in_valid, out_ready, tm_empty, tm_full,
    output in_ready, out_valid, tm_write, tm_read, out_row, out_last, busy, err
`ifdef IC_BD_TRANSPOSE_CTRL_BLKCNT_EN
    , output blk_cnt
`endif
  );

  // Row stage, column stage and buffer side.
  modport slave (
    output in_valid, out_ready, tm_empty, tm_full,
    input  in_ready, out_valid, tm_write, tm_read, out_row, out_last, busy, err
`ifdef IC_BD_TRANSPOSE_CTRL_BLKCNT_EN
    , input blk_cnt
`endif
  );

endinterface

// File: rtl/ic_bd_out_stage.sv
// Tracks the buffer's registered output: valid flag, row index and last-row marker.
// A read reloads it; a consume without a read empties it; back-pressure holds it.
module ic_bd_out_stage #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rd_en,
  input  logic             out_ready,
  input  logic [CNT_W-1:0] rd_idx,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_row,
  output logic             out_last
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_last  <= 1'b0;
    end else if (rd_en) begin
      out_valid <= 1'b1;
      out_row   <= rd_idx;
      out_last  <= (rd_idx == CNT_W'(ROWS - 1));
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ic_bd_transpose_ctrl.sv
// Sequences the 8x8 transpose buffer: fills ROWS rows from the row stage, then drains them.
// Optional block counter enabled by IC_BD_TRANSPOSE_CTRL_BLKCNT_EN.
module ic_bd_transpose_ctrl
  import ic_bd_pkg::*;
#(
  parameter int unsigned ROWS  = ROWS_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  ic_bd_transpose_ctrl_if.master bus
);

  state_e           state;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] rd_cnt;
  logic             drain_first;
  logic             err_c;

  assign bus.in_ready = (state == ST_IDLE) || (state == ST_FILL);
  assign bus.tm_write = bus.in_valid && bus.in_ready;
  assign bus.tm_read  = (state == ST_DRAIN) && (!bus.out_valid || bus.out_ready);
  assign bus.busy     = (state != ST_IDLE);

  // Buffer flags must agree with the controller's own occupancy view.
  assign err_c = ((state == ST_FILL) && bus.tm_full && (wr_cnt < CNT_W'(ROWS)))
              || (bus.tm_read && bus.tm_empty)
              || (drain_first && !bus.tm_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      drain_first <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      drain_first <= 1'b0;
      if (err_c) bus.err <= 1'b1;
      case (state)
        ST_IDLE, ST_FILL: begin
          if (bus.tm_write) begin
            if (wr_cnt == CNT_W'(ROWS - 1)) begin
              state       <= ST_DRAIN;
              wr_cnt      <= '0;
              drain_first <= 1'b1;
            end else begin
              state  <= ST_FILL;
              wr_cnt <= wr_cnt + CNT_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (bus.tm_read) begin
            if (rd_cnt == CNT_W'(ROWS - 1)) begin
              state  <= ST_IDLE;
              rd_cnt <= '0;
            end else begin
              rd_cnt <= rd_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ic_bd_out_stage #(
    .ROWS  (ROWS),
    .CNT_W (CNT_W)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .rd_en     (bus.tm_read),
    .out_ready (bus.out_ready),
    .rd_idx    (rd_cnt),
    .out_valid (bus.out_valid),
    .out_row   (bus.out_row),
    .out_last  (bus.out_last)
  );

`ifdef IC_BD_TRANSPOSE_CTRL_BLKCNT_EN
  logic [15:0] blk_cnt_q;

  // Counts completed blocks at the consumer handshake of the last row.
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= 16'd0;
    end else if (bus.out_last && bus.out_valid && bus.out_ready) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end

  assign bus.blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_ic_bd_transpose_ctrl.sv
// Directed self-checking bench for ic_bd_transpose_ctrl with a simple buffer occupancy model.
// Covers IC_BD_TRANSPOSE_CTRL_BLKCNT_EN when that macro is defined.
module tb_ic_bd_transpose_ctrl;

  logic clk;
  logic reset;
  logic force_full;
  logic [4:0] bcnt;
  int vecs;
  int errs;

  ic_bd_transpose_ctrl_if #(.CNT_W(4)) bus ();

  ic_bd_transpose_ctrl #(.ROWS(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer occupancy model: flags follow the registered entry count.
  always_ff @(posedge clk) begin
    if (reset) bcnt <= 5'd0;
    else       bcnt <= bcnt + 5'(bus.tm_write) - 5'(bus.tm_read);
  end
  assign bus.tm_full  = (bcnt == 5'd8) || force_full;
  assign bus.tm_empty = (bcnt == 5'd0);

  task automatic test_reset;
    reset = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 1'b0; force_full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.out_row !== 4'd0 || bus.out_last !== 1'b0 ||
        bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset_state: valid=%b row=%0d last=%b err=%b busy=%b in_ready=%b, required 0 0 0 0 0 1",
               bus.out_valid, bus.out_row, bus.out_last, bus.err, bus.busy, bus.in_ready);
    end
  endtask

  task automatic do_writes(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); bus.in_valid = 1'b1; #1;
      vecs++;
      if (bus.tm_write !== 1'b1 || bus.tm_read !== 1'b0) begin
        errs++;
        $display("FAIL write_%0d: tm_write=%b tm_read=%b, required 1 0", i, bus.tm_write, bus.tm_read);
      end
    end
    @(negedge clk); bus.in_valid = 1'b0;
  endtask

  task automatic test_full_block(input int tag);
    bus.out_ready = 1'b1;
    do_writes(8);
    #1;
    vecs++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
      errs++;
      $display("FAIL blk%0d_drain_entry: in_ready=%b busy=%b out_valid=%b, required 0 1 0",
               tag, bus.in_ready, bus.busy, bus.out_valid);
    end
    for (int j = 0; j < 8; j++) begin
      if (j > 0) begin @(negedge clk); #1; end
      vecs++;
      if (bus.tm_read !== 1'b1) begin
        errs++;
        $display("FAIL blk%0d_read_%0d: tm_read=%b, required 1", tag, j, bus.tm_read);
      end
      if (j > 0) begin
        vecs++;
        if (bus.out_valid !== 1'b1 || bus.out_row !== 4'(j - 1) || bus.out_last !== 1'b0) begin
          errs++;
          $display("FAIL blk%0d_row_%0d: valid=%b row=%0d last=%b, required 1 %0d 0",
                   tag, j - 1, bus.out_valid, bus.out_row, bus.out_last, j - 1);
        end
      end
    end
    @(negedge clk); #1;
    vecs++;
    if (bus.out_valid !== 1'b1 || bus.out_row !== 4'd7 || bus.out_last !== 1'b1 ||
        bus.busy !== 1'b0 || bus.tm_read !== 1'b0) begin
      errs++;
      $display("FAIL blk%0d_last_row: valid=%b row=%0d last=%b busy=%b tm_read=%b, required 1 7 1 0 0",
               tag, bus.out_valid, bus.out_row, bus.out_last, bus.busy, bus.tm_read);
    end
    @(negedge clk); #1;
    vecs++;
    if (bus.out_valid !== 1'b0 || bus.err !== 1'b0) begin
      errs++;
      $display("FAIL blk%0d_done: out_valid=%b err=%b, required 0 0", tag, bus.out_valid, bus.err);
    end
  endtask

  task automatic test_backpressure;
    int hs;
    int cyc;
    int exp_row;
    bus.out_ready = 1'b1;
    do_writes(8);
    hs = 0; cyc = 0; exp_row = 0;
    while (hs < 8 && cyc < 60) begin
      bus.out_ready = (cyc % 3 == 0);
      #1;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        vecs++;
        if (bus.tm_read !== 1'b0) begin
          errs++;
          $display("FAIL bp_stall_cyc%0d: tm_read=%b, required 0", cyc, bus.tm_read);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        vecs++;
        if (bus.out_row !== 4'(exp_row) || bus.out_last !== (exp_row == 7)) begin
          errs++;
          $display("FAIL bp_row_%0d: row=%0d last=%b, required %0d %b",
                   exp_row, bus.out_row, bus.out_last, exp_row, exp_row == 7);
        end
        exp_row++;
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b1;
    #1;
    vecs++;
    if (hs != 8 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      errs++;
      $display("FAIL bp_done: handshakes=%0d valid=%b busy=%b err=%b, required 8 0 0 0",
               hs, bus.out_valid, bus.busy, bus.err);
    end
  endtask

  task automatic test_drain_blocks_input;
    bus.out_ready = 1'b1;
    do_writes(8);
    bus.in_valid = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      #1;
      vecs++;
      if (bus.in_ready !== 1'b0 || bus.tm_write !== 1'b0 || bus.tm_read !== 1'b1) begin
        errs++;
        $display("FAIL drain_in_%0d: in_ready=%b tm_write=%b tm_read=%b, required 0 0 1",
                 j, bus.in_ready, bus.tm_write, bus.tm_read);
      end
    end
    @(negedge clk); #1;
    vecs++;
    if (bus.in_ready !== 1'b1 || bus.tm_write !== 1'b1) begin
      errs++;
      $display("FAIL drain_resume: in_ready=%b tm_write=%b, required 1 1", bus.in_ready, bus.tm_write);
    end
    @(negedge clk); bus.in_valid = 1'b0;
  endtask

  task automatic test_reset_mid_block;
    reset = 1'b1; bus.in_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    do_writes(5);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    vecs++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset: busy=%b out_valid=%b in_ready=%b, required 0 0 1",
               bus.busy, bus.out_valid, bus.in_ready);
    end
    test_full_block(2);
  endtask

  task automatic test_err;
    do_writes(3);
    force_full = 1'b1; #1;
    vecs++;
    if (bus.err !== 1'b0) begin
      errs++;
      $display("FAIL err_before: err=%b, required 0", bus.err);
    end
    @(negedge clk); force_full = 1'b0; #1;
    vecs++;
    if (bus.err !== 1'b1) begin
      errs++;
      $display("FAIL err_set: err=%b, required 1", bus.err);
    end
    bus.out_ready = 1'b1;
    do_writes(5);
    repeat (10) @(negedge clk);
    #1;
    vecs++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL err_sticky: err=%b busy=%b, required 1 0", bus.err, bus.busy);
    end
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    vecs++;
    if (bus.err !== 1'b0) begin
      errs++;
      $display("FAIL err_clear: err=%b, required 0", bus.err);
    end
  endtask

`ifdef IC_BD_TRANSPOSE_CTRL_BLKCNT_EN
  task automatic test_blk_cnt;
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int b = 0; b < 3; b++) test_full_block(10 + b);
    vecs++;
    if (bus.blk_cnt !== 16'd3) begin
      errs++;
      $display("FAIL blk_cnt_3: blk_cnt=%0d, required 3", bus.blk_cnt);
    end
    force dut.blk_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    test_full_block(20);
    vecs++;
    if (bus.blk_cnt !== 16'd0) begin
      errs++;
      $display("FAIL blk_cnt_wrap: blk_cnt=%0h, required 0", bus.blk_cnt);
    end
  endtask
`endif

  initial begin
    vecs = 0; errs = 0;
    reset = 1'b1; force_full = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_full_block(1);
    test_backpressure();
    test_drain_blocks_input();
    test_reset_mid_block();
    test_err();
`ifdef IC_BD_TRANSPOSE_CTRL_BLKCNT_EN
    test_blk_cnt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ic_bd_transpose_ctrl.md
Name: ic_bd_transpose_ctrl

Overview:
Controller that sequences the 8x8 transpose buffer between the row-pass and column-pass 1-D DCT stages of the bindct processor.
- Accepts 8 row vectors from the row stage with a valid/ready handshake and issues 8 buffer writes.
- Then issues 8 buffer reads toward the column stage with a valid/ready handshake, honouring the buffer's 1-cycle registered read latency.
- Control only: the 96-bit data path runs directly from the row stage to the buffer and from the buffer to the column stage.

Parameters:
- ROWS, 8, rows per block; writes per fill and reads per drain.
- CNT_W, 4, width of the row counters; must hold the value ROWS.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  row stage presents a row vector.
- in_ready  out  1  controller accepts a row this cycle.
- out_valid  out  1  buffer output register holds a valid column vector.
- out_ready  in  1  column stage consumes the vector.
- tm_write  out  1  buffer write request.
- tm_read  out  1  buffer read request.
- tm_empty  in  1  buffer empty flag.
- tm_full  in  1  buffer full flag.
- out_row  out  CNT_W  index (0..ROWS-1) of the vector currently on the output.
- out_last  out  1  out_valid row is the last row of the block.
- busy  out  1  state is not IDLE.
- err  out  1  sticky: buffer flags disagree with controller count.

Behaviour:
- Reset: state=IDLE, wr_cnt=0, rd_cnt=0, out_valid=0, out_row=0, out_last=0, err=0.
- Combinational outputs: in_ready = (state==IDLE or FILL); tm_write = in_valid & in_ready; tm_read = (state==DRAIN) & (~out_valid | out_ready).
- IDLE:
  - A write moves to FILL with wr_cnt=1.
  - If ROWS==1, it moves to DRAIN instead.
- FILL:
  - Each write increments wr_cnt.
  - The write that makes wr_cnt==ROWS moves to DRAIN and clears wr_cnt.
  - No read is issued in FILL.
- DRAIN:
  - in_ready=0.
  - Each tm_read increments rd_cnt.
  - The read that makes rd_cnt==ROWS moves to IDLE and clears rd_cnt.
  - A write and a read are never issued in the same cycle.
- Output register:
  - tm_read sets out_valid=1 the next cycle, with out_row=rd_cnt (value before increment) and out_last=(rd_cnt==ROWS-1).
  - out_valid & out_ready with no tm_read clears out_valid.
  - out_valid & out_ready with tm_read keeps out_valid=1 and loads the new row. This gives back-to-back throughput of 1 row/cycle.
  - While out_valid & ~out_ready, tm_read stays 0 and out_row/out_last hold.
- Latency:
  - First column vector is valid 1 cycle after DRAIN entry, at the earliest.
  - Full block: 8 write cycles + 8 read cycles + 1 = 17 cycles minimum.
- The final vector may still be pending in IDLE; a new fill may start while it waits. The buffer's output register is independent of writes.
- err is set, and stays set until reset, when any of these hold:
  - tm_full=1 in FILL with wr_cnt<ROWS;
  - tm_empty=1 on a cycle that issues tm_read;
  - tm_full=0 on DRAIN entry +1 cycle.
- Synchronous reset mid-block returns to the reset state immediately and drops any pending out_valid. The buffer is reset by the same signal.
- Undefined in_valid/out_ready in IDLE with no handshake: no state change.

Optional Feature:
- Macro: IC_BD_TRANSPOSE_CTRL_BLKCNT_EN.
- When defined:
  - Adds output blk_cnt (16 bits), reset to 0.
  - Increments when out_last & out_valid & out_ready.
  - Wraps 0xFFFF -> 0x0000.
- When undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package ic_bd_pkg holds:
  - state encoding localparams: IDLE=2'd0, FILL=2'd1, DRAIN=2'd2;
  - ROWS default 8;
  - row-vector width 96 and element width 12.
- One natural sub-module, ic_bd_out_stage: out_valid/out_row/out_last register with its hold/advance logic. The FSM and counters stay in the top module.

Test Plan:
- Reset, then in_valid=1 for 8 cycles, out_ready=1 -> 8 tm_write pulses, DRAIN entered on the 9th cycle, 8 tm_read pulses, out_row 0..7 on consecutive cycles, out_last only with out_row=7, back to IDLE, err=0.
- Same fill, out_ready toggling 1,0,0,1,... -> tm_read suppressed whenever out_valid=1 & out_ready=0; out_row never skips or repeats; exactly 8 out handshakes.
- in_valid during DRAIN -> in_ready=0, no tm_write; fill resumes only after rd_cnt reaches 8.
- reset asserted after the 5th write -> next cycle state=IDLE, wr_cnt=0, out_valid=0; a fresh 8-row block completes normally.
- Force tm_full=1 after the 3rd write -> err=1 next cycle and stays 1 through the block; cleared only by reset.
- With IC_BD_TRANSPOSE_CTRL_BLKCNT_EN defined, stream 3 blocks -> blk_cnt=3; preload 0xFFFF via force and complete 1 block -> blk_cnt=0.
